instr_fetch_unit: RTL and testbench

Front end of the single-cycle-control MIPS core: owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and holds them in an instruction register. Drives OPCode/FCode and the register/immediate fields into the control decoder and datapath, then consumes the decoder's 2-bit Branch code plus the ALU zero flag to select the next PC. Each instruction passes through a three-state fetch/decode/execute sequence.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS front end: PC, instruction fetch handshake, IR and next-PC select
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [5:0]  OPCode,
    output logic [5:0]  FCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic        instr_valid,
    input  logic [1:0]  Branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [15:0] retire_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] retire_count_q, retire_count_d;

    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    // Next-PC selection from the decoder branch code and the ALU zero flag
    always_comb begin
        pc4           = pc_q + 32'd4;
        branch_target = pc4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        jump_target   = {pc4[31:28], ir_q[25:0], 2'b00};
        next_pc       = pc4;
        case (Branch)
            BR_BEQ:  if (zero)  next_pc = branch_target;
            BR_BNE:  if (!zero) next_pc = branch_target;
            BR_JUMP: next_pc = jump_target;
            default: next_pc = pc4;
        endcase
    end

    // Fetch/decode/execute sequencing; PC and retire count advance only when EXEC closes
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        retire_count_d = retire_count_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d           = next_pc;
                retire_count_d = retire_count_q + 16'd1;
                state_d        = enable ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, IR and retire counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            ir_q           <= 32'd0;
            retire_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Handshake and valid strobes come straight from the state register so they cannot glitch
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        instr_valid = (state_q == S_EXEC);
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign retire_count = retire_count_q;
    assign instr        = ir_q;
    assign OPCode       = ir_q[31:26];
    assign FCode        = ir_q[5:0];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign shamt        = ir_q[10:6];
    assign imm          = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [1:0]  Branch;
    logic        zero;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [5:0]  OPCode, FCode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic        instr_valid;
    logic [31:0] pc;
    logic [15:0] retire_count;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_instr;
    logic [5:0]  w_OPCode, w_FCode;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm;
    logic        w_instr_valid;
    logic [31:0] w_pc;
    logic [15:0] w_retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .enable(enable),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .OPCode(OPCode), .FCode(FCode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .instr_valid(instr_valid), .Branch(Branch), .zero(zero),
        .pc(pc), .retire_count(retire_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(w_instr), .OPCode(w_OPCode), .FCode(w_FCode),
        .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .imm(w_imm),
        .instr_valid(w_instr_valid), .Branch(Branch), .zero(zero),
        .pc(w_pc), .retire_count(w_retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one instruction starting from a FETCH (or soon-to-be FETCH) state.
    // Branch/zero carry inverted junk outside EXEC, which the unit must ignore.
    task automatic run_instr(input logic [31:0] ins, input logic [1:0] br, input logic z,
                             input int waits, input logic drop_en,
                             input logic [31:0] pc_before, input logic [31:0] pc_after,
                             input logic [15:0] rc_after);
        int guard;
        guard = 0;
        Branch = ~br;
        zero   = ~z;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        imem_data = ins;
        for (int k = 0; k < waits; k++) begin
            imem_ack = 1'b0;
            if (drop_en && k == 1) enable = 1'b0;
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, pc_before);
            @(negedge clk);
        end
        check("fetch_addr", imem_addr, pc_before);
        check("fetch_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
        check("dec_ir", instr, ins);
        check("dec_req", {31'd0, imem_req}, 32'd0);
        check("dec_valid", {31'd0, instr_valid}, 32'd0);
        check("dec_pc", pc, pc_before);
        Branch = br;
        zero   = z;
        @(negedge clk);
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_pc", pc, pc_before);
        @(negedge clk);
        Branch = ~br;
        zero   = ~z;
        check("next_pc", pc, pc_after);
        check("retire", {16'd0, retire_count}, {16'd0, rc_after});
        check("post_valid", {31'd0, instr_valid}, 32'd0);
        check("ir_hold", instr, ins);
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  br;
        logic        z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[13];
    logic [31:0] cur_pc;
    logic [15:0] cur_rc;

    initial begin
        vecs[0]  = '{32'h0022_1820, 2'b11, 1'b0, 32'h0000_0004};  // add
        vecs[1]  = '{32'h0022_1820, 2'b11, 1'b0, 32'h0000_0008};  // add
        vecs[2]  = '{32'h1022_0003, 2'b00, 1'b1, 32'h0000_0018};  // BEQ taken 8+4+12
        vecs[3]  = '{32'h1422_FFFB, 2'b01, 1'b0, 32'h0000_0008};  // BNE back 28-20
        vecs[4]  = '{32'h1022_0003, 2'b00, 1'b0, 32'h0000_000C};  // BEQ not taken
        vecs[5]  = '{32'h0022_1820, 2'b11, 1'b0, 32'h0000_0010};  // add
        vecs[6]  = '{32'h1422_FFFE, 2'b01, 1'b0, 32'h0000_000C};  // BNE 20-8
        vecs[7]  = '{32'h1422_FFFE, 2'b01, 1'b1, 32'h0000_0010};  // BNE not taken
        vecs[8]  = '{32'h0BFF_FFFF, 2'b10, 1'b0, 32'h0FFF_FFFC};  // J to top of region
        vecs[9]  = '{32'h0022_1820, 2'b11, 1'b0, 32'h1000_0000};  // add crosses region
        vecs[10] = '{32'h0800_0004, 2'b10, 1'b1, 32'h1000_0010};  // J keeps pc4[31:28]
        vecs[11] = '{32'h0800_0040, 2'b10, 1'b0, 32'h1000_0100};  // J
        vecs[12] = '{32'h1022_0003, 2'b11, 1'b1, 32'h1000_0104};  // Branch=11 ignores zero

        rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
        Branch = 2'b11; zero = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", instr, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_rc", {16'd0, retire_count}, 32'd0);
        @(negedge clk);
        check("idle_req", {31'd0, imem_req}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("en_req", {31'd0, imem_req}, 32'd1);

        cur_pc = 32'h0;
        cur_rc = 16'd0;
        for (int i = 0; i < 13; i++) begin
            cur_rc = cur_rc + 16'd1;
            run_instr(vecs[i].ins, vecs[i].br, vecs[i].z, 0, 1'b0, cur_pc, vecs[i].exp_pc, cur_rc);
            if (i == 0) begin
                check("opcode", {26'd0, OPCode}, 32'h0);
                check("fcode", {26'd0, FCode}, 32'h20);
                check("rs", {27'd0, rs}, 32'd1);
                check("rt", {27'd0, rt}, 32'd2);
                check("rd", {27'd0, rd}, 32'd3);
                check("shamt", {27'd0, shamt}, 32'd0);
                check("imm", {16'd0, imm}, 32'h1820);
            end
            cur_pc = vecs[i].exp_pc;
        end

        // Four ack wait cycles with enable dropped mid-wait: retire, then park in IDLE
        cur_rc = cur_rc + 16'd1;
        run_instr(32'h0022_1820, 2'b11, 1'b0, 4, 1'b1, cur_pc, cur_pc + 32'd4, cur_rc);
        cur_pc = cur_pc + 32'd4;
        check("park_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("park_req2", {31'd0, imem_req}, 32'd0);
        check("park_pc", pc, cur_pc);

        // Reset asserted during DECODE takes effect before the next edge
        enable = 1'b1;
        @(negedge clk);
        imem_data = 32'h1234_5678;
        imem_ack  = 1'b1;
        @(negedge clk);
        check("pre_rst_ir", instr, 32'h1234_5678);
        #1 rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_ir", instr, 32'h0);
        check("arst_op", {26'd0, OPCode}, 32'h0);
        check("arst_rc", {16'd0, retire_count}, 32'd0);
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_wpc", w_pc, 32'hFFFF_FFFC);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("stale_ack_ir", instr, 32'h0);
        check("stale_ack_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;

        // PC wrap on the unit reset to 32'hFFFF_FFFC
        enable = 1'b1;
        run_instr(32'h0022_1820, 2'b11, 1'b0, 0, 1'b0, 32'h0, 32'h4, 16'd1);
        check("wrap_pc", w_pc, 32'h0);
        check("wrap_rc", {16'd0, w_retire_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
